axis_vid_out: RTL and testbench
===============================

AXIS_VID_OUT -- requirements
Module: axis_vid_out

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 The block SHALL have parameters H_FP, H_SYNC and H_BP, defaults 16, 96 and 48, giving horizontal front porch, sync width and back porch in clocks.
REQ-003 The block SHALL have parameters V_ACTIVE, V_FP, V_SYNC and V_BP, defaults 480, 10, 2 and 33, giving vertical timing in lines.
REQ-004 The block SHALL have parameters HSYNC_POL and VSYNC_POL, default 0 each, giving the asserted level of the corresponding sync output.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 Port clk SHALL be an input, 1 bit wide: the pixel clock.
REQ-007 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-008 Port en SHALL be an input, 1 bit wide: run enable.
REQ-009 Port s_data SHALL be an input, 24 bits wide: pixel as {red, grn, blu}.
REQ-010 Port s_vld SHALL be an input, 1 bit wide: stream beat valid.
REQ-011 Port s_sof SHALL be an input, 1 bit wide: beat is the first pixel of a frame.
REQ-012 Port s_rdy SHALL be an output, 1 bit wide: beat accepted when s_vld and s_rdy are both 1.
REQ-013 Ports data_o (24 bits), vde_o, hsync_o and vsync_o (1 bit each) SHALL be outputs forming the video output.
REQ-014 Port locked SHALL be an output, 1 bit wide: the block is in the RUN state.
REQ-015 Port underflow SHALL be an output, 1 bit wide: sticky flag, set when an active pixel had no data; cleared only by rst.
REQ-016 Port desync SHALL be an output, 1 bit wide: one-cycle pulse on a frame misalignment.

Function
REQ-017 Define H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOT likewise; hcnt SHALL count 0..H_TOT-1 and wrap to 0, and on that wrap vcnt SHALL increment, wrapping from V_TOT-1 to 0.
REQ-018 Counters SHALL advance only while en=1; while en=0 they SHALL hold, s_rdy SHALL be 0, and outputs SHALL take their reset values.
REQ-019 A position is active when hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-020 hsync SHALL be asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
REQ-021 vsync SHALL be asserted for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, over whole lines.
REQ-022 All video outputs SHALL be registered with a latency of 1 clock: the state at counter position (h,v) in cycle t appears on the outputs in cycle t+1, and a beat accepted in cycle t appears on data_o in cycle t+1.
REQ-023 The FSM SHALL have the states WAIT_SOF, ARMED and RUN.
REQ-024 In WAIT_SOF: s_rdy = s_vld & ~s_sof, so non-SOF beats are dropped; an SOF beat present SHALL move the FSM to ARMED without being consumed.
REQ-025 In ARMED: s_rdy=0 except at (hcnt,vcnt)=(0,0) with en=1, where s_rdy=1, the SOF beat is consumed as pixel (0,0), and the FSM moves to RUN.
REQ-026 In RUN: s_rdy=1 at active positions and 0 elsewhere.
REQ-027 In RUN, at an active position with s_vld=0: data_o SHALL be 24'h000000 for that pixel, underflow SHALL be set, and the FSM SHALL stay in RUN.
REQ-028 In RUN, an SOF beat at an active position other than (0,0): the beat SHALL NOT be consumed (s_rdy=0), desync SHALL pulse, the output pixel SHALL be black, and the FSM SHALL go to ARMED.
REQ-029 In RUN at (0,0), a valid non-SOF beat SHALL be consumed and discarded, desync SHALL pulse, the pixel SHALL be black, and the FSM SHALL go to WAIT_SOF.
REQ-030 vde_o SHALL follow the active region in all states; data_o SHALL be 0 whenever vde_o=0 or the FSM is not in RUN, except the pixel consumed per REQ-025.
REQ-031 locked SHALL be 1 in RUN and 0 otherwise, registered together with the video outputs.
REQ-032 Deasserting en SHALL NOT change the FSM state.

Reset
REQ-033 While rst=1, the block SHALL set hcnt=0, vcnt=0 and FSM=WAIT_SOF.
REQ-034 While rst=1, the outputs SHALL be: data_o=0, vde_o=0, hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL, s_rdy=0, locked=0, underflow=0, desync=0.
REQ-035 rst asserted mid-frame SHALL take effect on the next clock edge, with no pending beat retained.

Verification (H 4/1/2/1 gives H_TOT=8; V 3/1/1/1 gives V_TOT=6; POL=0)
REQ-036 Continuous stream, SOF on pixel 0, en=1 -> frame of 48 clocks, vde_o high 4 of every 8 clocks on lines 0-2, hsync_o low at h=5,6, vsync_o low for all of line 4, locked=1 from first pixel.
REQ-037 Pixel values 1..12 as s_data, first beat with SOF -> data_o shows 1..12 in raster order, each 1 clock after its counter position; s_rdy=0 during blanking.
REQ-038 s_vld dropped for pixel (2,1) -> data_o=0 for that pixel, underflow=1 and stays 1, remaining pixels unshifted.
REQ-039 Three non-SOF beats before the SOF -> all three dropped in WAIT_SOF, output starts with the SOF pixel at (0,0) of the next frame.
REQ-040 SOF beat arriving at (1,1) in RUN -> desync pulses once, beat held (s_rdy=0) until the next (0,0), then consumed, locked back to 1.
REQ-041 rst pulsed at (3,2) -> next cycle: all outputs at reset values, counters at 0, FSM in WAIT_SOF.

Source files
------------

// File: rtl/axis_vid_out.sv
// AXI-stream to raster video converter: free-running H/V timing generator that
// locks an incoming pixel stream to the frame origin using the SOF marker.
module axis_vid_out #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] s_data,
    input  logic        s_vld,
    input  logic        s_sof,
    output logic        s_rdy,
    output logic [23:0] data_o,
    output logic        vde_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        locked,
    output logic        underflow,
    output logic        desync
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT + 1);
    localparam int VW    = $clog2(V_TOT + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ARMED    = 2'd1,
        RUN      = 2'd2
    } state_t;

    logic [HW-1:0] hcnt_r;
    logic [VW-1:0] vcnt_r;
    state_t        state_r;
    state_t        state_s;
    logic          active_s;
    logic          origin_s;
    logic          hs_s;
    logic          vs_s;
    logic          rdy_s;
    logic          under_s;
    logic          desync_s;
    logic [23:0]   pix_s;
    logic [23:0]   data_r;
    logic          vde_r;
    logic          hsync_r;
    logic          vsync_r;
    logic          locked_r;
    logic          underflow_r;
    logic          desync_r;

    assign active_s = (hcnt_r < H_ACT) && (vcnt_r < V_ACT);
    assign origin_s = (hcnt_r == {HW{1'b0}}) && (vcnt_r == {VW{1'b0}});
    assign hs_s     = (hcnt_r >= H_SS) && (hcnt_r < H_SE);
    assign vs_s     = (vcnt_r >= V_SS) && (vcnt_r < V_SE);

    // Raster position counters; they freeze while the block is disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_r <= {HW{1'b0}};
            vcnt_r <= {VW{1'b0}};
        end else if (en) begin
            if (hcnt_r == H_LAST) begin
                hcnt_r <= {HW{1'b0}};
                vcnt_r <= (vcnt_r == V_LAST) ? {VW{1'b0}} : vcnt_r + 1'b1;
            end else begin
                hcnt_r <= hcnt_r + 1'b1;
            end
        end else begin
            hcnt_r <= hcnt_r;
            vcnt_r <= vcnt_r;
        end
    end

    // Frame-lock state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WAIT_SOF;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame-lock next state; a disabled block keeps its lock state
    always_comb begin
        state_s = state_r;
        if (en) begin
            case (state_r)
                WAIT_SOF: begin
                    if (s_vld && s_sof) state_s = ARMED;
                    else                state_s = WAIT_SOF;
                end
                ARMED: begin
                    if (origin_s && s_vld) state_s = s_sof ? RUN : WAIT_SOF;
                    else                   state_s = ARMED;
                end
                RUN: begin
                    if (active_s && s_vld && s_sof && !origin_s) state_s = ARMED;
                    else if (origin_s && s_vld && !s_sof)        state_s = WAIT_SOF;
                    else                                         state_s = RUN;
                end
                default: state_s = WAIT_SOF;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Handshake and pixel selection; a misplaced SOF is held back for the next origin
    always_comb begin
        rdy_s    = 1'b0;
        pix_s    = 24'h000000;
        under_s  = 1'b0;
        desync_s = 1'b0;
        if (en && !rst) begin
            case (state_r)
                WAIT_SOF: rdy_s = s_vld & ~s_sof;
                ARMED: begin
                    if (origin_s) begin
                        rdy_s = 1'b1;
                        pix_s = (s_vld && s_sof) ? s_data : 24'h000000;
                    end else begin
                        rdy_s = 1'b0;
                    end
                end
                RUN: begin
                    if (active_s) begin
                        if (!s_vld) begin
                            rdy_s   = 1'b1;
                            under_s = 1'b1;
                        end else if (s_sof && !origin_s) begin
                            rdy_s    = 1'b0;
                            desync_s = 1'b1;
                        end else if (!s_sof && origin_s) begin
                            rdy_s    = 1'b1;
                            desync_s = 1'b1;
                        end else begin
                            rdy_s = 1'b1;
                            pix_s = s_data;
                        end
                    end else begin
                        rdy_s = 1'b0;
                    end
                end
                default: rdy_s = 1'b0;
            endcase
        end else begin
            rdy_s = 1'b0;
        end
    end

    // Registered video outputs; underflow stays sticky across disable
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r      <= 24'h000000;
            vde_r       <= 1'b0;
            hsync_r     <= ~HSYNC_POL;
            vsync_r     <= ~VSYNC_POL;
            locked_r    <= 1'b0;
            underflow_r <= 1'b0;
            desync_r    <= 1'b0;
        end else if (!en) begin
            data_r      <= 24'h000000;
            vde_r       <= 1'b0;
            hsync_r     <= ~HSYNC_POL;
            vsync_r     <= ~VSYNC_POL;
            locked_r    <= 1'b0;
            underflow_r <= underflow_r;
            desync_r    <= 1'b0;
        end else begin
            data_r      <= pix_s;
            vde_r       <= active_s;
            hsync_r     <= hs_s ? HSYNC_POL : ~HSYNC_POL;
            vsync_r     <= vs_s ? VSYNC_POL : ~VSYNC_POL;
            locked_r    <= (state_s == RUN);
            underflow_r <= underflow_r | under_s;
            desync_r    <= desync_s;
        end
    end

    assign s_rdy     = rdy_s;
    assign data_o    = data_r;
    assign vde_o     = vde_r;
    assign hsync_o   = hsync_r;
    assign vsync_o   = vsync_r;
    assign locked    = locked_r;
    assign underflow = underflow_r;
    assign desync    = desync_r;

endmodule

// File: tb/tb_axis_vid_out.sv
// Bench for axis_vid_out on a tiny 8x6 raster: a queue-driven stream source and a
// position-arithmetic reference model predict every output cycle.
module tb_axis_vid_out;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int HUNT = 0, ARMED_M = 1, RUNNING = 2;
    localparam logic [29:0] RST_VEC = {24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [23:0] s_data = 24'h000000;
    logic        s_vld = 1'b0;
    logic        s_sof = 1'b0;
    logic        s_rdy;
    logic [23:0] data_o;
    logic        vde_o, hsync_o, vsync_o, locked, underflow, desync;
    logic [29:0] out_vec;

    axis_vid_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .s_data(s_data), .s_vld(s_vld), .s_sof(s_sof), .s_rdy(s_rdy),
        .data_o(data_o), .vde_o(vde_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .locked(locked), .underflow(underflow), .desync(desync)
    );

    always #5 clk = ~clk;

    assign out_vec = {data_o, vde_o, hsync_o, vsync_o, locked, underflow, desync};

    typedef struct {
        logic        sof;
        logic [23:0] d;
    } beat_t;

    beat_t       q[$];
    logic [23:0] cap[$];
    logic [23:0] exp_cap[$];
    int          errors = 0;
    int          checks = 0;
    int          mpos = 0;
    int          mmode = HUNT;
    bit          munder = 1'b0;
    bit          gaps = 1'b0;
    int          drop_at = -1;
    logic [29:0] exp_vec;
    logic        exp_rdy;
    logic        got_rdy;

    // One clock: present the queue head, predict the cycle, advance at the edge.
    task automatic step();
        int h, v, nm;
        bit act, org, drop, uf, des;
        logic [23:0] pix;
        drop = (drop_at >= 0) && (mpos == drop_at) && (mmode == RUNNING) && en && !rst;
        if (drop) begin
            drop_at = -1;
            if (q.size() > 0) q.delete(0);
        end
        s_vld = (q.size() > 0) && !drop && !(gaps && ($urandom_range(0, 3) == 0));
        if (q.size() > 0) begin
            s_sof  = q[0].sof;
            s_data = q[0].d;
        end else begin
            s_sof  = 1'b0;
            s_data = 24'($urandom);
        end
        #1;
        got_rdy = s_rdy;
        h = mpos % HT;
        v = mpos / HT;
        act = (h < HA) && (v < VA);
        org = (mpos == 0);
        pix = 24'h000000;
        uf = 1'b0;
        des = 1'b0;
        exp_rdy = 1'b0;
        nm = mmode;
        if (rst) begin
            mpos = 0;
            mmode = HUNT;
            munder = 1'b0;
            exp_vec = RST_VEC;
        end else if (!en) begin
            exp_vec = {24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, munder, 1'b0};
        end else begin
            if (mmode == HUNT) begin
                exp_rdy = s_vld && !s_sof;
                if (s_vld && s_sof) nm = ARMED_M;
            end else if (mmode == ARMED_M) begin
                if (org) begin
                    exp_rdy = 1'b1;
                    if (s_vld && s_sof) begin
                        pix = s_data;
                        nm = RUNNING;
                    end else if (s_vld) begin
                        nm = HUNT;
                    end
                end
            end else if (act) begin
                if (!s_vld) begin
                    exp_rdy = 1'b1;
                    uf = 1'b1;
                end else if (s_sof && !org) begin
                    des = 1'b1;
                    nm = ARMED_M;
                end else if (!s_sof && org) begin
                    exp_rdy = 1'b1;
                    des = 1'b1;
                    nm = HUNT;
                end else begin
                    exp_rdy = 1'b1;
                    pix = s_data;
                end
            end
            munder = munder | uf;
            exp_vec = {pix, act, ~((h >= HA + HF) && (h < HA + HF + HS)),
                       ~((v >= VA + VF) && (v < VA + VF + VS)), (nm == RUNNING), munder, des};
            mmode = nm;
            mpos = (mpos + 1) % FR;
        end
        @(posedge clk);
        if (exp_rdy && s_vld && q.size() > 0) q.delete(0);
        @(negedge clk);
    endtask

    task automatic push_frame(input int n, input bit rnd, input int base);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.sof = (i == 0);
            b.d = rnd ? 24'($urandom) : 24'(base + i);
            q.push_back(b);
            exp_cap.push_back(b.d);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b1;
        gaps = 1'b0;
        drop_at = -1;
        q.delete();
        cap.delete();
        exp_cap.delete();
        step();
        rst = 1'b0;
    endtask

    function automatic int cap_diff();
        int n = 0;
        if (cap.size() != exp_cap.size()) return -1;
        foreach (cap[i]) if (cap[i] !== exp_cap[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        beat_t b;
        rst = 1'b1;
        en = 1'b1;
        q.delete();
        b.sof = 1'b0;
        b.d = 24'h123456;
        q.push_back(b);
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 2;
            if (out_vec !== RST_VEC) begin errors++; $display("FAIL reset_out got=%h exp=%h", out_vec, RST_VEC); end
            if (got_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", got_rdy); end
        end
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_stream();
        int first_lock = -1, n_vde = 0, n_hs = 0, n_vs = 0;
        do_reset();
        push_frame(HA * VA, 1'b0, 1);
        push_frame(HA * VA, 1'b1, 0);
        for (int i = 1; i <= 3 * FR; i++) begin
            step();
            checks += 2;
            if (out_vec !== exp_vec) begin errors++; $display("FAIL stream_out step=%0d got=%h exp=%h", i, out_vec, exp_vec); end
            if (got_rdy !== exp_rdy) begin errors++; $display("FAIL stream_rdy step=%0d got=%b exp=%b", i, got_rdy, exp_rdy); end
            if (vde_o && locked) cap.push_back(data_o);
            if (locked && first_lock < 0) first_lock = i;
            n_vde += int'(vde_o);
            n_hs += int'(!hsync_o);
            n_vs += int'(!vsync_o);
        end
        checks += 5;
        if (cap_diff() != 0) begin errors++; $display("FAIL stream_pixels got=%0d diffs exp=0 (n=%0d)", cap_diff(), cap.size()); end
        if (first_lock != FR + 1) begin errors++; $display("FAIL stream_lock got=%0d exp=%0d", first_lock, FR + 1); end
        if (n_vde != 3 * HA * VA) begin errors++; $display("FAIL stream_vde got=%0d exp=%0d", n_vde, 3 * HA * VA); end
        if (n_hs != 3 * VT * HS) begin errors++; $display("FAIL stream_hsync got=%0d exp=%0d", n_hs, 3 * VT * HS); end
        if (n_vs != 3 * VS * HT) begin errors++; $display("FAIL stream_vsync got=%0d exp=%0d", n_vs, 3 * VS * HT); end
    endtask

    task automatic test_underflow();
        int first_uf = -1;
        do_reset();
        push_frame(HA * VA, 1'b1, 0);
        push_frame(HA * VA, 1'b1, 0);
        exp_cap[1 * HA + 2] = 24'h000000;
        drop_at = 1 * HT + 2;
        for (int i = 1; i <= 3 * FR; i++) begin
            step();
            checks += 2;
            if (out_vec !== exp_vec) begin errors++; $display("FAIL uflow_out step=%0d got=%h exp=%h", i, out_vec, exp_vec); end
            if (got_rdy !== exp_rdy) begin errors++; $display("FAIL uflow_rdy step=%0d got=%b exp=%b", i, got_rdy, exp_rdy); end
            if (vde_o && locked) cap.push_back(data_o);
            if (underflow && first_uf < 0) first_uf = i;
        end
        checks += 3;
        if (cap_diff() != 0) begin errors++; $display("FAIL uflow_pixels got=%0d diffs exp=0", cap_diff()); end
        if (first_uf != FR + HT + 2 + 1) begin errors++; $display("FAIL uflow_when got=%0d exp=%0d", first_uf, FR + HT + 3); end
        if (underflow !== 1'b1) begin errors++; $display("FAIL uflow_sticky got=%b exp=1", underflow); end
    endtask

    task automatic test_pre_sof();
        beat_t b;
        int first_lock = -1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            b.sof = 1'b0;
            b.d = 24'($urandom);
            q.push_back(b);
        end
        push_frame(HA * VA, 1'b1, 0);
        for (int i = 1; i <= 2 * FR; i++) begin
            step();
            checks += 2;
            if (out_vec !== exp_vec) begin errors++; $display("FAIL presof_out step=%0d got=%h exp=%h", i, out_vec, exp_vec); end
            if (got_rdy !== exp_rdy) begin errors++; $display("FAIL presof_rdy step=%0d got=%b exp=%b", i, got_rdy, exp_rdy); end
            if (vde_o && locked) cap.push_back(data_o);
            if (locked && first_lock < 0) first_lock = i;
        end
        checks += 2;
        if (cap_diff() != 0) begin errors++; $display("FAIL presof_pixels got=%0d diffs exp=0", cap_diff()); end
        if (first_lock != FR + 1) begin errors++; $display("FAIL presof_lock got=%0d exp=%0d", first_lock, FR + 1); end
    endtask

    task automatic test_desync();
        int n_des = 0, des_at = -1;
        do_reset();
        push_frame(HT - HA + 1, 1'b1, 0);
        push_frame(HA * VA, 1'b1, 0);
        for (int i = 1; i <= 3 * FR; i++) begin
            step();
            checks += 2;
            if (out_vec !== exp_vec) begin errors++; $display("FAIL desync_out step=%0d got=%h exp=%h", i, out_vec, exp_vec); end
            if (got_rdy !== exp_rdy) begin errors++; $display("FAIL desync_rdy step=%0d got=%b exp=%b", i, got_rdy, exp_rdy); end
            if (vde_o && locked) cap.push_back(data_o);
            if (desync) begin
                n_des++;
                des_at = i;
            end
        end
        checks += 4;
        if (n_des != 1) begin errors++; $display("FAIL desync_count got=%0d exp=1", n_des); end
        if (des_at != FR + HT + 1 + 1) begin errors++; $display("FAIL desync_when got=%0d exp=%0d", des_at, FR + HT + 2); end
        if (locked !== 1'b1) begin errors++; $display("FAIL desync_relock got=%b exp=1", locked); end
        if (cap_diff() != 0) begin errors++; $display("FAIL desync_pixels got=%0d diffs exp=0", cap_diff()); end
    endtask

    task automatic test_enable();
        do_reset();
        push_frame(HA * VA, 1'b1, 0);
        push_frame(HA * VA, 1'b1, 0);
        for (int i = 1; i <= 3 * FR + 7; i++) begin
            en = !(i > 60 && i <= 67);
            step();
            checks += 2;
            if (out_vec !== exp_vec) begin errors++; $display("FAIL enable_out step=%0d got=%h exp=%h", i, out_vec, exp_vec); end
            if (got_rdy !== exp_rdy) begin errors++; $display("FAIL enable_rdy step=%0d got=%b exp=%b", i, got_rdy, exp_rdy); end
            if (vde_o && locked) cap.push_back(data_o);
        end
        en = 1'b1;
        checks += 1;
        if (cap_diff() != 0) begin errors++; $display("FAIL enable_pixels got=%0d diffs exp=0", cap_diff()); end
    endtask

    task automatic test_rst_mid();
        int guard = 0;
        do_reset();
        push_frame(HA * VA, 1'b1, 0);
        push_frame(HA * VA, 1'b1, 0);
        while (!(mmode == RUNNING && mpos == 2 * HT + 3) && guard < 4 * FR) begin
            step();
            guard++;
        end
        checks += 1;
        if (guard >= 4 * FR) begin errors++; $display("FAIL rstmid_reach got=%0d exp<%0d", guard, 4 * FR); end
        rst = 1'b1;
        step();
        checks += 2;
        if (out_vec !== RST_VEC) begin errors++; $display("FAIL rstmid_out got=%h exp=%h", out_vec, RST_VEC); end
        if (got_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_rdy got=%b exp=0", got_rdy); end
        rst = 1'b0;
        q.delete();
        step();
        checks += 2;
        if (out_vec !== {24'h000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rstmid_origin got=%h exp=%h", out_vec, {24'h000000, 1'b1, 1'b1, 1'b1, 3'b000});
        end
        if (out_vec !== exp_vec) begin errors++; $display("FAIL rstmid_model got=%h exp=%h", out_vec, exp_vec); end
    endtask

    task automatic test_random();
        do_reset();
        gaps = 1'b1;
        push_frame(HA * VA, 1'b1, 0);
        push_frame(HA * VA, 1'b1, 0);
        push_frame(HA * VA, 1'b1, 0);
        for (int i = 1; i <= 200; i++) begin
            en = ($urandom_range(0, 9) != 0);
            step();
            checks += 2;
            if (out_vec !== exp_vec) begin errors++; $display("FAIL random_out step=%0d got=%h exp=%h", i, out_vec, exp_vec); end
            if (got_rdy !== exp_rdy) begin errors++; $display("FAIL random_rdy step=%0d got=%b exp=%b", i, got_rdy, exp_rdy); end
        end
        en = 1'b1;
        gaps = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_underflow();
        test_pre_sof();
        test_desync();
        test_enable();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
